// File: rtl/rf_pkg.sv
// Shared constants, clear-sequencer state type and index-width helper
// for the pipelined register file with scoreboard.
package rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {
    IDLE,
    CLEAR
  } rf_clr_state_t;

  function automatic int idx_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// Decode/writeback-facing bus of the register file: read, write, reserve and clear.
interface rf_scoreboard_if
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
);

  localparam int AW = idx_width(NREG);

  logic [AW-1:0]   rR1;
  logic [AW-1:0]   rR2;
  logic [XLEN-1:0] rD1;
  logic [XLEN-1:0] rD2;
  logic            rf_we;
  logic [AW-1:0]   wR;
  logic [XLEN-1:0] wD;
  logic            rsv_en;
  logic [AW-1:0]   rsv_r;
  logic            hazard;
  logic [AW:0]     busy_cnt;
  logic            clr_req;
  logic            clr_busy;

  modport master (
    output rR1, rR2, rf_we, wR, wD, rsv_en, rsv_r, clr_req,
    input  rD1, rD2, hazard, busy_cnt, clr_busy
  );

  modport slave (
    input  rR1, rR2, rf_we, wR, wD, rsv_en, rsv_r, clr_req,
    output rD1, rD2, hazard, busy_cnt, clr_busy
  );

endinterface

// File: rtl/rf_clr_seq.sv
// Clear sequencer: on request, walks idx from 1 to NREG-1 issuing one
// zeroing write per cycle while clr_busy_o is high.
module rf_clr_seq
  import rf_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  localparam int AW   = idx_width(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req_i,
  output logic          clr_busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_idx_o,
  output logic          clr_start_o
);

  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NREG - 1);

  rf_clr_state_t state_q;
  logic [AW-1:0] idx_q;
  logic          busy_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req_i) begin
            state_q <= CLEAR;
            idx_q   <= IDX_FIRST;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (idx_q == IDX_LAST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + IDX_FIRST;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // clr_start is the accept strobe: the top wipes the scoreboard on this edge.
  assign clr_start_o = (state_q == IDLE) && clr_req_i;
  assign clr_busy_o  = busy_q;
  assign clr_we_o    = busy_q;
  assign clr_idx_o   = idx_q;

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with two combinational read ports, one write port, write-to-read
// bypass, per-register busy scoreboard with hazard detection, and a clear sequencer.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREG   = NREG_DEF,
  parameter  int BYPASS = 1,
  localparam int AW     = idx_width(NREG)
) (
  input logic            clk,
  input logic            rst_n,
  rf_scoreboard_if.slave rf
);

  localparam bit          BYP_EN  = (BYPASS != 0);
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;

  logic          clr_busy, clr_we, clr_start;
  logic [AW-1:0] clr_idx;

  rf_clr_seq #(.NREG(NREG)) u_clr_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_req_i   (rf.clr_req),
    .clr_busy_o  (clr_busy),
    .clr_we_o    (clr_we),
    .clr_idx_o   (clr_idx),
    .clr_start_o (clr_start)
  );

  logic idle, we_ok, rsv_ok;
  assign idle   = !clr_busy;
  assign we_ok  = idle && !rf.clr_req && rf.rf_we  && (rf.wR    != '0);
  assign rsv_ok = idle && !rf.clr_req && rf.rsv_en && (rf.rsv_r != '0);

  // Bypass match is used by hazard even without forwarding; data forwarding
  // is additionally suppressed during reset and while clearing.
  logic byp1, byp2, fwd1, fwd2;
  assign byp1 = BYP_EN && rf.rf_we && (rf.wR == rf.rR1);
  assign byp2 = BYP_EN && rf.rf_we && (rf.wR == rf.rR2);
  assign fwd1 = byp1 && idle && rst_n;
  assign fwd2 = byp2 && idle && rst_n;

  assign rf.rD1 = (rf.rR1 == '0) ? '0 : (fwd1 ? rf.wD : regs_q[rf.rR1]);
  assign rf.rD2 = (rf.rR2 == '0) ? '0 : (fwd2 ? rf.wD : regs_q[rf.rR2]);

  assign rf.hazard = clr_busy
                   || ((rf.rR1 != '0) && busy_q[rf.rR1] && !byp1)
                   || ((rf.rR2 != '0) && busy_q[rf.rR2] && !byp2);

  assign rf.busy_cnt = cnt_q;
  assign rf.clr_busy = clr_busy;

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (clr_start) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (rsv_ok && !busy_q[rf.rsv_r]) begin
        cnt_d = cnt_d + CNT_ONE;
      end
      if (we_ok && busy_q[rf.wR] && !(rsv_ok && (rf.rsv_r == rf.wR))) begin
        cnt_d = cnt_d - CNT_ONE;
      end
      // Release first, reserve second: a new producer overrides the release.
      if (we_ok)  busy_d[rf.wR]    = 1'b0;
      if (rsv_ok) busy_d[rf.rsv_r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: the array is architecturally reset to zero, so it is built from
  // resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (clr_we) begin
      regs_q[clr_idx] <= '0;
    end else if (we_ok) begin
      regs_q[rf.wR] <= rf.wD;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench: BYPASS=1 and BYPASS=0 instances share one stimulus stream
// and are compared every cycle against a behavioural register-file model.
module tb_rf_scoreboard;
  import rf_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   rR1, rR2, wR, rsv_r;
  logic [XLEN-1:0] wD;
  logic            rf_we, rsv_en, clr_req;

  rf_scoreboard_if #(.XLEN(XLEN), .NREG(NREG)) if1 ();
  rf_scoreboard_if #(.XLEN(XLEN), .NREG(NREG)) if0 ();

  assign if1.rR1 = rR1;  assign if0.rR1 = rR1;
  assign if1.rR2 = rR2;  assign if0.rR2 = rR2;
  assign if1.rf_we = rf_we;  assign if0.rf_we = rf_we;
  assign if1.wR = wR;  assign if0.wR = wR;
  assign if1.wD = wD;  assign if0.wD = wD;
  assign if1.rsv_en = rsv_en;  assign if0.rsv_en = rsv_en;
  assign if1.rsv_r = rsv_r;  assign if0.rsv_r = rsv_r;
  assign if1.clr_req = clr_req;  assign if0.clr_req = clr_req;

  rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut1 (.clk(clk), .rst_n(rst_n), .rf(if1));
  rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut0 (.clk(clk), .rst_n(rst_n), .rf(if0));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural contents, reservation set, clear progress.
  logic [XLEN-1:0] m_reg [NREG];
  bit   [NREG-1:0] m_busy;
  bit              m_clear;
  int              m_next;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_busy  = '0;
      m_clear = 1'b0;
      m_next  = 0;
    end else if (m_clear) begin
      m_reg[m_next] = '0;
      m_next++;
      if (m_next == NREG) m_clear = 1'b0;
    end else if (clr_req) begin
      m_clear = 1'b1;
      m_next  = 1;
      m_busy  = '0;
    end else begin
      if (rf_we && wR != 0) begin
        m_reg[wR] = wD;
        m_busy[wR] = 1'b0;
      end
      if (rsv_en && rsv_r != 0) m_busy[rsv_r] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input int b, input logic [AW-1:0] r);
    if (r == 0) return '0;
    if (b != 0 && rst_n && rf_we && wR == r && !m_clear) return wD;
    return m_reg[r];
  endfunction

  function automatic bit exp_haz(input int b);
    bit h;
    h = 1'b0;
    if (!rst_n) return 1'b0;
    if (m_clear) return 1'b1;
    if (rR1 != 0 && m_busy[rR1] && !(b != 0 && rf_we && wR == rR1)) h = 1'b1;
    if (rR2 != 0 && m_busy[rR2] && !(b != 0 && rf_we && wR == rR2)) h = 1'b1;
    return h;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd1_byp1", 64'(if1.rD1), 64'(exp_rd(1, rR1)));
      check("rd2_byp1", 64'(if1.rD2), 64'(exp_rd(1, rR2)));
      check("rd1_byp0", 64'(if0.rD1), 64'(exp_rd(0, rR1)));
      check("rd2_byp0", 64'(if0.rD2), 64'(exp_rd(0, rR2)));
      check("haz_byp1", 64'(if1.hazard), 64'(exp_haz(1)));
      check("haz_byp0", 64'(if0.hazard), 64'(exp_haz(0)));
      check("cnt_byp1", 64'(if1.busy_cnt), 64'($countones(m_busy)));
      check("cnt_byp0", 64'(if0.busy_cnt), 64'($countones(m_busy)));
      check("clr_byp1", 64'(if1.clr_busy), 64'(m_clear));
      check("clr_byp0", 64'(if0.clr_busy), 64'(m_clear));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rf_we   = 1'b0;
    rsv_en  = 1'b0;
    clr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_len;
    idle_in();
    rR1 = '0; rR2 = '0; wR = '0; wD = '0; rsv_r = '0;
    chk_en = 1'b1;

    // Reset held with a write presented: reads must stay 0, nothing written.
    rf_we = 1'b1; wR = 5'd3; wD = '1; rR1 = 5'd3; rR2 = 5'd3;
    repeat (3) @(posedge clk);
    #2;
    check("rst_rd1", 64'(if1.rD1), 64'h0);
    check("rst_haz", 64'(if1.hazard), 64'h0);
    check("rst_cnt", 64'(if1.busy_cnt), 64'h0);
    check("rst_clr", 64'(if1.clr_busy), 64'h0);
    idle_in();
    rst_n = 1'b1;
    tick();

    // Basic write then read; writes to x0 are dropped.
    rf_we = 1'b1; wR = 5'd5; wD = 32'hDEADBEEF;
    tick();
    rf_we = 1'b0; rR1 = 5'd5;
    #2;
    check("x5_b1", 64'(if1.rD1), 64'hDEADBEEF);
    check("x5_b0", 64'(if0.rD1), 64'hDEADBEEF);
    tick();
    rf_we = 1'b1; wR = 5'd0; wD = 32'h1234; rR2 = 5'd0;
    #2;
    check("x0_same", 64'(if1.rD2), 64'h0);
    tick();
    rf_we = 1'b0;
    #2;
    check("x0_after", 64'(if1.rD2), 64'h0);

    // Bypass versus no bypass.
    tick();
    rf_we = 1'b1; wR = 5'd7; wD = 32'h11111111;
    tick();
    wD = 32'hA5A5A5A5; rR1 = 5'd7;
    #2;
    check("byp_on", 64'(if1.rD1), 64'hA5A5A5A5);
    check("byp_off", 64'(if0.rD1), 64'h11111111);
    check("byp_haz", 64'(if1.hazard), 64'h0);
    tick();
    rf_we = 1'b0;
    #2;
    check("byp_off_next", 64'(if0.rD1), 64'hA5A5A5A5);

    // Scoreboard: reserve, hazard, release, reserve+write collision, x0.
    rsv_en = 1'b1; rsv_r = 5'd3;
    tick();
    rsv_r = 5'd4;
    tick();
    rsv_en = 1'b0; rR1 = 5'd3;
    #2;
    check("sb_cnt2", 64'(if1.busy_cnt), 64'd2);
    check("sb_haz", 64'(if1.hazard), 64'h1);
    tick();
    rf_we = 1'b1; wR = 5'd3; wD = 32'h33;
    #2;
    check("sb_wr_haz_b1", 64'(if1.hazard), 64'h0);
    check("sb_wr_haz_b0", 64'(if0.hazard), 64'h1);
    tick();
    rf_we = 1'b0;
    #2;
    check("sb_cnt1", 64'(if1.busy_cnt), 64'd1);
    check("sb_haz_drop", 64'(if0.hazard), 64'h0);
    rsv_en = 1'b1; rsv_r = 5'd4; rf_we = 1'b1; wR = 5'd4; wD = 32'h44;
    tick();
    idle_in(); rR1 = 5'd4;
    #2;
    check("sb_rsvwr_cnt", 64'(if1.busy_cnt), 64'd1);
    check("sb_rsvwr_haz", 64'(if1.hazard), 64'h1);
    check("sb_rsvwr_data", 64'(if0.rD1), 64'h44);
    rf_we = 1'b1; wR = 5'd4; wD = 32'h45;
    tick();
    rf_we = 1'b0; rsv_en = 1'b1; rsv_r = 5'd0; rR1 = 5'd0;
    tick();
    rsv_en = 1'b0;
    #2;
    check("x0_rsv_cnt", 64'(if1.busy_cnt), 64'd0);
    check("x0_rsv_haz", 64'(if1.hazard), 64'h0);

    // Randomised traffic, including occasional clears.
    for (int k = 0; k < 600; k++) begin
      tick();
      rR1     = AW'($urandom_range(0, 9));
      rR2     = AW'($urandom_range(0, NREG - 1));
      rf_we   = ($urandom_range(0, 2) == 0);
      wR      = AW'($urandom_range(0, 9));
      wD      = $urandom;
      rsv_en  = ($urandom_range(0, 2) == 0);
      rsv_r   = AW'($urandom_range(0, 9));
      clr_req = ($urandom_range(0, 79) == 0);
    end
    tick();
    idle_in();
    repeat (NREG + 1) tick();

    // Directed clear: fill, reserve, request with discarded write/reserve.
    for (int i = 1; i < NREG; i++) begin
      rf_we = 1'b1; wR = AW'(i); wD = 32'h1000_0000 | (i * 32'h101);
      tick();
    end
    rf_we = 1'b0; rsv_en = 1'b1; rsv_r = 5'd9;
    tick();
    clr_req = 1'b1; rf_we = 1'b1; wR = 5'd2; wD = 32'hFFFF; rsv_en = 1'b1; rsv_r = 5'd12;
    tick();
    clr_req = 1'b0;
    clr_len = 0;
    for (int k = 0; k < 40; k++) begin
      rf_we = 1'b1; wR = AW'($urandom_range(1, NREG - 1)); wD = $urandom;
      rR1 = AW'(k % NREG); rR2 = 5'd9;
      #2;
      if (!if1.clr_busy) break;
      clr_len++;
      check("clr_haz", 64'(if1.hazard), 64'h1);
      check("clr_cnt", 64'(if1.busy_cnt), 64'd0);
      tick();
    end
    check("clr_len", 64'(clr_len), 64'd31);
    idle_in();
    for (int i = 0; i < NREG; i++) begin
      rR1 = AW'(i); rR2 = AW'(NREG - 1 - i);
      #1;
      check("clr_rd1", 64'(if1.rD1), 64'h0);
      check("clr_rd2", 64'(if0.rD2), 64'h0);
    end

    // Reset in the middle of a clear sequence.
    tick();
    rf_we = 1'b1; wR = 5'd20; wD = 32'h2020_2020;
    tick();
    rf_we = 1'b0; rsv_en = 1'b1; rsv_r = 5'd9;
    tick();
    rsv_en = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (15) tick();
    rR1 = 5'd20; rR2 = 5'd20;
    #2;
    check("mid_clr_old", 64'(if1.rD1), 64'h2020_2020);
    rst_n = 1'b0;
    #1;
    check("arst_clr", 64'(if1.clr_busy), 64'h0);
    check("arst_cnt", 64'(if1.busy_cnt), 64'd0);
    check("arst_rd", 64'(if1.rD1), 64'h0);
    check("arst_haz", 64'(if1.hazard), 64'h0);
    rst_n = 1'b1;
    tick();
    rf_we = 1'b1; wR = 5'd6; wD = 32'hCAFEF00D;
    tick();
    rf_we = 1'b0; rR1 = 5'd6;
    #2;
    check("post_rst_wr", 64'(if1.rD1), 64'hCAFEF00D);
    check("post_rst_x20", 64'(if0.rD2), 64'h0);
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised successor to the single-cycle register file, for the pipelined core.
- Register array with two combinational read ports and one synchronous write port.
- Adds write-to-read bypass, a per-register busy scoreboard (reserve at issue, release at writeback), hazard detection and a reserved-count output.
- Adds a sequential clear sequencer that zeroes the array one register per cycle on request.
- Sits between decode (read/reserve) and writeback (write/release).

Parameters:
XLEN, 32, data width of each register.
NREG, 32, number of architectural registers, power of two, at least 4.
AW, $clog2(NREG), register index width (derived, not overridden).
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
rR1  in  AW  read index, port 1.
rR2  in  AW  read index, port 2.
rD1  out  XLEN  read data, port 1, combinational.
rD2  out  XLEN  read data, port 2, combinational.
rf_we  in  1  write enable, also releases busy[wR].
wR  in  AW  write index.
wD  in  XLEN  write data.
rsv_en  in  1  reserve destination register at issue.
rsv_r  in  AW  register index to reserve.
hazard  out  1  a read port targets a busy register whose value is not available this cycle.
busy_cnt  out  AW+1  number of registers currently reserved.
clr_req  in  1  single-cycle request to clear the whole register file.
clr_busy  out  1  clear sequence in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers are set to 0 and all busy bits are cleared.
  - busy_cnt = 0, FSM = IDLE, clr_busy = 0.
  - While reset is held, rD1/rD2 read 0 and hazard = 0.
- Register 0:
  - Always reads 0.
  - Writes, reserves and busy updates to index 0 are ignored.
  - Index 0 never contributes to hazard.
- Reads (0-cycle latency):
  - rDn = 0 if rRn == 0.
  - Otherwise rDn = wD if BYPASS, rf_we, wR == rRn and state is IDLE.
  - Otherwise rDn = reg[rRn].
- Write (IDLE only): on the rising edge with rf_we and wR != 0, reg[wR] <= wD and busy[wR] <= 0.
- Reserve (IDLE only): on the rising edge with rsv_en and rsv_r != 0, busy[rsv_r] <= 1.
- Reserve and write to the same index in the same cycle: reserve wins and busy stays 1, because a new producer has been issued. The data is still written.
- busy_cnt is updated incrementally and always equals the popcount of the busy vector:
  - +1 when a 0 bit is set.
  - -1 when a 1 bit is cleared and not re-reserved.
  - Net effect: 0, +1, -1 or +1-1 for disjoint reserve and release indices.
  - Width AW+1 holds values 0..NREG-1 and never wraps.
- hazard = OR over n = 1, 2 of: rRn != 0 and busy[rRn] and not (BYPASS and rf_we and wR == rRn).
  - During CLEAR, hazard is forced to 1.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE with clr_req: go to CLEAR.
    - All busy bits are cleared and busy_cnt <= 0 on that edge.
    - Index counter idx <= 1.
    - clr_busy rises in the next cycle.
    - A rf_we or rsv_en presented in the same cycle as clr_req is discarded.
  - CLEAR, each cycle: reg[idx] <= 0 and idx <= idx + 1.
    - When idx == NREG-1, that register is cleared and the FSM returns to IDLE.
    - Total clr_busy high time = NREG-1 cycles.
  - During CLEAR:
    - rf_we, rsv_en and clr_req are ignored.
    - Reads return current contents: registers already cleared read 0, the rest still read old data.
    - Bypass is disabled.
  - Reset mid-CLEAR: immediate return to IDLE with everything cleared.

Decomposition:
- Package rf_pkg holds:
  - default XLEN and NREG constants;
  - state enum rf_clr_state_t {IDLE, CLEAR};
  - helper function for index width.
- One natural sub-module: rf_clr_seq. It contains the FSM and idx counter and outputs clr_busy, clr_we, clr_idx and clr_start.
- The storage array, bypass, scoreboard and busy_cnt remain in the top module.

Test Plan:
- Reset, then write x5=0xDEADBEEF. Next cycle rR1=5 -> rD1=0xDEADBEEF. Write x0=0x1234 -> rR2=0 reads 0.
- Bypass: in the same cycle rf_we, wR=7, wD=0xA5A5A5A5, rR1=7 -> rD1=0xA5A5A5A5 combinationally and hazard=0. Repeat with BYPASS=0 -> rD1 returns the old value.
- Scoreboard:
  - Reserve x3 and x4 -> busy_cnt=2.
  - rR1=3 -> hazard=1.
  - Write x3 -> busy_cnt=1, hazard drops the cycle after the write.
  - Reserve and write x4 in the same cycle -> busy_cnt stays 1 and busy[4]=1.
- Reserve x0 -> busy_cnt stays 0 and rR1=0 gives hazard=0.
- Clear with NREG=32:
  - Fill x1..x31 with nonzero values, reserve x9, pulse clr_req.
  - Expect busy_cnt=0 and clr_busy high for exactly 31 cycles, hazard=1 throughout, then all reads return 0.
  - rf_we during the sequence has no effect.
- Deassert rst_n asynchronously (mid-cycle) halfway through CLEAR -> clr_busy=0, busy_cnt=0 and all registers read 0 immediately. After rst_n goes high, normal writes work on the next edge.
